// File: rtl/dp_request_arbiter.sv
// Shares the BCU data-pointer port between microcode (rq0) and the interrupt/stack sequencer (rq1).
// Latency: grant on a ce_1 tick, ack one clk after the ce_1 that samples dp_ready (min 4 ce_1 ticks).
// Backpressure: requests are level-held until ack; the BCU stalls the active access via dp_ready.
module dp_request_arbiter #(
   parameter bit         RR_MODE = 1'b1,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        ce_1,
   input  logic        ce_2,
   input  logic        rq0_req,
   input  logic        rq0_lock,
   input  logic [15:0] rq0_addr,
   input  logic [15:0] rq0_dout,
   input  logic [1:0]  rq0_sreg,
   input  logic        rq0_write,
   input  logic        rq0_wide,
   input  logic        rq0_io,
   input  logic        rq0_zero_seg,
   output logic        rq0_ack,
   input  logic        rq1_req,
   input  logic        rq1_lock,
   input  logic [15:0] rq1_addr,
   input  logic [15:0] rq1_dout,
   input  logic [1:0]  rq1_sreg,
   input  logic        rq1_write,
   input  logic        rq1_wide,
   input  logic        rq1_io,
   input  logic        rq1_zero_seg,
   output logic        rq1_ack,
   output logic [15:0] rq_din,
   output logic [15:0] dp_addr,
   output logic [15:0] dp_dout,
   output logic [1:0]  dp_sreg,
   output logic        dp_write,
   output logic        dp_wide,
   output logic        dp_io,
   output logic        dp_zero_seg,
   output logic        dp_req,
   input  logic        dp_ready,
   input  logic [15:0] dp_din,
   output logic        owner,
   output logic        busy,
   output logic        fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        last_winner;
   logic        locked;
   logic [7:0]  wdog;
   logic [7:0]  wdog_inc;
   logic [1:0]  req_vld;
   logic [1:0]  elig;
   logic        own_req;
   logic        lock_hold;
   logic        grant_vld;
   logic        win;
   logic        grant_fire;
   logic        issue_done;
   logic        done_fire;
   logic        wait_miss;

   // Winner selection; a requester being acked this clk is masked so it is never re-granted on its own ack.
   always_comb begin
      req_vld   = {rq1_req & ~rq1_ack, rq0_req & ~rq0_ack};
      own_req   = owner ? rq1_req : rq0_req;
      lock_hold = locked & own_req;
      elig      = req_vld;
      if (lock_hold) begin
         elig = owner ? (req_vld & 2'b10) : (req_vld & 2'b01);
      end
      grant_vld = |elig;
      if (elig == 2'b11) begin
         win = RR_MODE ? ~last_winner : 1'b0;
      end else begin
         win = elig[1];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; every transition is qualified by the phase-1 enable.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ce_1 && grant_vld) state_nxt = ISSUE;
         ISSUE:   if (ce_1 && !dp_req)   state_nxt = WAIT;
         WAIT:    if (ce_1 && dp_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output and event decode from the current state.
   always_comb begin
      busy       = (state != IDLE);
      grant_fire = (state == IDLE)  && ce_1 && grant_vld;
      issue_done = (state == ISSUE) && ce_1 && !dp_req;
      done_fire  = (state == WAIT)  && ce_1 && dp_ready;
      wait_miss  = (state == WAIT)  && ce_1 && !dp_ready;
      wdog_inc   = wdog + 8'd1;
   end

   // Latch the winner's access; fields stay frozen until the next grant.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         dp_addr     <= 16'h0000;
         dp_dout     <= 16'h0000;
         dp_sreg     <= 2'd0;
         dp_write    <= 1'b0;
         dp_wide     <= 1'b0;
         dp_io       <= 1'b0;
         dp_zero_seg <= 1'b0;
         owner       <= 1'b0;
      end else if (grant_fire) begin
         dp_addr     <= win ? rq1_addr     : rq0_addr;
         dp_dout     <= win ? rq1_dout     : rq0_dout;
         dp_sreg     <= win ? rq1_sreg     : rq0_sreg;
         dp_write    <= win ? rq1_write    : rq0_write;
         dp_wide     <= win ? rq1_wide     : rq0_wide;
         dp_io       <= win ? rq1_io       : rq0_io;
         dp_zero_seg <= win ? rq1_zero_seg : rq0_zero_seg;
         owner       <= win;
      end
   end

   // dp_req lives for exactly one enable tick (ce_1 or ce_2) after the grant.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         dp_req <= 1'b0;
      end else if (grant_fire) begin
         dp_req <= 1'b1;
      end else if (ce_1 || ce_2) begin
         dp_req <= 1'b0;
      end
   end

   // Completion: return data, one-clk ack, round-robin history and lock capture.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rq_din      <= 16'h0000;
         rq0_ack     <= 1'b0;
         rq1_ack     <= 1'b0;
         last_winner <= 1'b1;
         locked      <= 1'b0;
      end else begin
         rq0_ack <= done_fire & ~owner;
         rq1_ack <= done_fire & owner;
         if (done_fire) begin
            rq_din      <= dp_din;
            last_winner <= owner;
            locked      <= owner ? rq1_lock : rq0_lock;
         end else if ((state == IDLE) && ce_1 && locked && !own_req) begin
            locked <= 1'b0;
         end
      end
   end

   // Watchdog: counts unanswered WAIT ticks, saturates, and raises a sticky fault at TIMEOUT.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wdog  <= 8'd0;
         fault <= 1'b0;
      end else begin
         if (issue_done) begin
            wdog <= 8'd0;
         end else if (wait_miss && (wdog != 8'hFF)) begin
            wdog <= wdog_inc;
         end
         if (wait_miss && (TIMEOUT != 8'd0) && (wdog_inc == TIMEOUT)) begin
            fault <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dp_request_arbiter.sv
// Directed bench for dp_request_arbiter: one round-robin instance and one fixed-priority instance.
// The bench plays both requesters and the BCU; expected values are hand-derived per scenario.
// A global time limit guarantees termination.
module tb_dp_request_arbiter;

   logic        clk, n_reset, ce_1, ce_2;
   logic        rq0_req, rq0_lock, rq0_write, rq0_wide, rq0_io, rq0_zero_seg;
   logic [15:0] rq0_addr, rq0_dout;
   logic [1:0]  rq0_sreg;
   logic        rq1_req, rq1_lock, rq1_write, rq1_wide, rq1_io, rq1_zero_seg;
   logic [15:0] rq1_addr, rq1_dout;
   logic [1:0]  rq1_sreg;
   logic        dp_ready;
   logic [15:0] dp_din;

   logic        rq0_ack, rq1_ack, dp_write, dp_wide, dp_io, dp_zero_seg, dp_req, owner, busy, fault;
   logic [15:0] rq_din, dp_addr, dp_dout;
   logic [1:0]  dp_sreg;

   logic        f_rq0_ack, f_rq1_ack, f_dp_write, f_dp_wide, f_dp_io, f_dp_zero_seg, f_dp_req;
   logic        f_owner, f_busy, f_fault;
   logic [15:0] f_rq_din, f_dp_addr, f_dp_dout;
   logic [1:0]  f_dp_sreg;

   bit sel;
   int total;
   int bad;

   logic        o_req, o_ack0, o_ack1, o_owner, o_busy, o_write;
   logic [15:0] o_addr, o_din;
   logic [5:0]  o_attr;

   assign o_req   = sel ? f_dp_req   : dp_req;
   assign o_ack0  = sel ? f_rq0_ack  : rq0_ack;
   assign o_ack1  = sel ? f_rq1_ack  : rq1_ack;
   assign o_owner = sel ? f_owner    : owner;
   assign o_busy  = sel ? f_busy     : busy;
   assign o_write = sel ? f_dp_write : dp_write;
   assign o_addr  = sel ? f_dp_addr  : dp_addr;
   assign o_din   = sel ? f_rq_din   : rq_din;
   assign o_attr  = sel ? {f_dp_sreg, f_dp_wide, f_dp_io, f_dp_zero_seg, f_dp_write}
                        : {dp_sreg, dp_wide, dp_io, dp_zero_seg, dp_write};

   dp_request_arbiter #(.RR_MODE(1'b1), .TIMEOUT(8'd255)) dut (
      .clk(clk), .n_reset(n_reset), .ce_1(ce_1), .ce_2(ce_2),
      .rq0_req(rq0_req), .rq0_lock(rq0_lock), .rq0_addr(rq0_addr), .rq0_dout(rq0_dout),
      .rq0_sreg(rq0_sreg), .rq0_write(rq0_write), .rq0_wide(rq0_wide), .rq0_io(rq0_io),
      .rq0_zero_seg(rq0_zero_seg), .rq0_ack(rq0_ack),
      .rq1_req(rq1_req), .rq1_lock(rq1_lock), .rq1_addr(rq1_addr), .rq1_dout(rq1_dout),
      .rq1_sreg(rq1_sreg), .rq1_write(rq1_write), .rq1_wide(rq1_wide), .rq1_io(rq1_io),
      .rq1_zero_seg(rq1_zero_seg), .rq1_ack(rq1_ack),
      .rq_din(rq_din), .dp_addr(dp_addr), .dp_dout(dp_dout), .dp_sreg(dp_sreg),
      .dp_write(dp_write), .dp_wide(dp_wide), .dp_io(dp_io), .dp_zero_seg(dp_zero_seg),
      .dp_req(dp_req), .dp_ready(dp_ready), .dp_din(dp_din),
      .owner(owner), .busy(busy), .fault(fault)
   );

   dp_request_arbiter #(.RR_MODE(1'b0), .TIMEOUT(8'd255)) dut_fp (
      .clk(clk), .n_reset(n_reset), .ce_1(ce_1), .ce_2(ce_2),
      .rq0_req(rq0_req), .rq0_lock(rq0_lock), .rq0_addr(rq0_addr), .rq0_dout(rq0_dout),
      .rq0_sreg(rq0_sreg), .rq0_write(rq0_write), .rq0_wide(rq0_wide), .rq0_io(rq0_io),
      .rq0_zero_seg(rq0_zero_seg), .rq0_ack(f_rq0_ack),
      .rq1_req(rq1_req), .rq1_lock(rq1_lock), .rq1_addr(rq1_addr), .rq1_dout(rq1_dout),
      .rq1_sreg(rq1_sreg), .rq1_write(rq1_write), .rq1_wide(rq1_wide), .rq1_io(rq1_io),
      .rq1_zero_seg(rq1_zero_seg), .rq1_ack(f_rq1_ack),
      .rq_din(f_rq_din), .dp_addr(f_dp_addr), .dp_dout(f_dp_dout), .dp_sreg(f_dp_sreg),
      .dp_write(f_dp_write), .dp_wide(f_dp_wide), .dp_io(f_dp_io), .dp_zero_seg(f_dp_zero_seg),
      .dp_req(f_dp_req), .dp_ready(dp_ready), .dp_din(dp_din),
      .owner(f_owner), .busy(f_busy), .fault(f_fault)
   );

   // Clock with alternating phase enables, changed on the falling edge.
   initial begin
      clk  = 1'b0;
      ce_1 = 1'b1;
      ce_2 = 1'b0;
      forever begin
         #5 clk = 1'b1;
         #5 clk = 1'b0;
         ce_1 = ~ce_1;
         ce_2 = ~ce_1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish before limit");
      $fatal(1);
   end

   task automatic ce1_tick();
      @(posedge clk);
      while (!ce_1) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rq0_req  = 1'b0;
      rq1_req  = 1'b0;
      dp_ready = 1'b0;
      n_reset  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_reset = 1'b1;
   endtask

   task automatic wait_grant(output bit ok);
      int n;
      n = 0;
      while (!o_req && n < 20) begin
         ce1_tick();
         n++;
      end
      ok = o_req;
   endtask

   // Plays the BCU for one access: ready is sampled on the 4th ce_1 after grant (+extra).
   task automatic serve(input int extra, input logic [15:0] din,
                        output bit granted, output bit gown, output bit one_pulse,
                        output bit ack_ok, output logic [15:0] addr_g, output logic [15:0] addr_c,
                        output bit busy_mid, output logic [5:0] attr_g);
      bit ok;
      granted = 1'b0; gown = 1'b0; one_pulse = 1'b0; ack_ok = 1'b0;
      addr_g = 16'h0; addr_c = 16'h0; busy_mid = 1'b0; attr_g = 6'h0;
      wait_grant(ok);
      if (!ok) return;
      granted = 1'b1;
      gown    = o_owner;
      addr_g  = o_addr;
      attr_g  = o_attr;
      @(posedge clk); #1;
      one_pulse = !o_req;
      repeat (3 + extra) ce1_tick();
      busy_mid = o_busy && !o_ack0 && !o_ack1;
      dp_ready = 1'b1;
      dp_din   = din;
      ce1_tick();
      addr_c = o_addr;
      ack_ok = (gown ? (o_ack1 && !o_ack0) : (o_ack0 && !o_ack1)) && !o_busy;
      dp_ready = 1'b0;
      if (gown) rq1_req = 1'b0; else rq0_req = 1'b0;
      @(posedge clk); #1;
      ack_ok = ack_ok && !o_ack0 && !o_ack1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (dp_req !== 1'b0) begin bad++; $display("FAIL reset_dp_req got=%b want=0", dp_req); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b want=0", owner); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
      total++; if (rq_din !== 16'h0000) begin bad++; $display("FAIL reset_rq_din got=%h want=0000", rq_din); end
      total++; if ({rq0_ack, rq1_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b want=00", {rq0_ack, rq1_ack}); end
      total++; if (dp_addr !== 16'h0000) begin bad++; $display("FAIL reset_dp_addr got=%h want=0000", dp_addr); end
   endtask

   task automatic test_single_read();
      bit g, o, p, a, b;
      logic [15:0] ag, ac;
      logic [5:0]  at;
      sel = 1'b0;
      rq0_addr = 16'h1234; rq0_sreg = 2'd3; rq0_wide = 1'b1; rq0_write = 1'b0;
      rq0_io = 1'b0; rq0_zero_seg = 1'b0; rq0_lock = 1'b0; rq0_dout = 16'h0000;
      rq0_req = 1'b1;
      serve(0, 16'hBEEF, g, o, p, a, ag, ac, b, at);
      total++; if (g !== 1'b1) begin bad++; $display("FAIL single_granted got=%b want=1", g); end
      total++; if (o !== 1'b0) begin bad++; $display("FAIL single_owner got=%b want=0", o); end
      total++; if (p !== 1'b1) begin bad++; $display("FAIL single_req_one_enable got=%b want=1", p); end
      total++; if (ag !== 16'h1234) begin bad++; $display("FAIL single_addr got=%h want=1234", ag); end
      total++; if (at !== 6'b11_1_0_0_0) begin bad++; $display("FAIL single_attr got=%b want=111000", at); end
      total++; if (b !== 1'b1) begin bad++; $display("FAIL single_busy_wait got=%b want=1", b); end
      total++; if (a !== 1'b1) begin bad++; $display("FAIL single_ack_one_clk got=%b want=1", a); end
      total++; if (rq_din !== 16'hBEEF) begin bad++; $display("FAIL single_rq_din got=%h want=beef", rq_din); end
   endtask

   task automatic test_round_robin();
      bit g, o, p, a, b;
      logic [15:0] ag, ac;
      logic [5:0]  at;
      do_reset();
      sel = 1'b0;
      rq0_addr = 16'h1000; rq1_addr = 16'h2000; rq1_lock = 1'b0; rq1_write = 1'b0;
      rq0_req = 1'b1; rq1_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         serve(0, 16'hA000 + 16'(i), g, o, p, a, ag, ac, b, at);
         total++; if (o !== i[0]) begin bad++; $display("FAIL rr_owner[%0d] got=%b want=%b", i, o, i[0]); end
         total++; if (ag !== (i[0] ? 16'h2000 : 16'h1000)) begin bad++; $display("FAIL rr_addr[%0d] got=%h want=%h", i, ag, (i[0] ? 16'h2000 : 16'h1000)); end
         total++; if (!(g && a)) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=1", i, g && a); end
         total++; if (o_din !== 16'hA000 + 16'(i)) begin bad++; $display("FAIL rr_rq_din[%0d] got=%h want=%h", i, o_din, 16'hA000 + 16'(i)); end
         if (i < 3) begin
            if (o) rq1_req = 1'b1; else rq0_req = 1'b1;
         end
      end
      rq0_req = 1'b0;
      rq1_req = 1'b0;
   endtask

   task automatic test_fixed_priority();
      bit g, o, p, a, b;
      logic [15:0] ag, ac;
      logic [5:0]  at;
      do_reset();
      sel = 1'b1;
      rq0_req = 1'b1; rq1_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         serve(0, 16'hC000 + 16'(i), g, o, p, a, ag, ac, b, at);
         total++; if (!(g && o == 1'b0)) begin bad++; $display("FAIL fp_owner[%0d] got=%b want=0", i, o); end
         total++; if (a !== 1'b1) begin bad++; $display("FAIL fp_ack[%0d] got=%b want=1", i, a); end
         if (i < 2) rq0_req = 1'b1;
      end
      rq1_req = 1'b0;
      sel = 1'b0;
      do_reset();
   endtask

   task automatic test_lock();
      bit g, o, p, a, b;
      logic [15:0] ag, ac;
      logic [5:0]  at;
      do_reset();
      sel = 1'b0;
      rq1_addr = 16'h3000; rq1_write = 1'b0; rq1_lock = 1'b1; rq1_req = 1'b1;
      serve(0, 16'h1111, g, o, p, a, ag, ac, b, at);
      total++; if (!(g && o == 1'b1 && a)) begin bad++; $display("FAIL lock_first got=%b%b%b want=111", g, o, a); end
      rq0_addr = 16'h1000; rq0_req = 1'b1;
      rq1_addr = 16'h3002; rq1_write = 1'b1; rq1_lock = 1'b0; rq1_req = 1'b1;
      serve(0, 16'h2222, g, o, p, a, ag, ac, b, at);
      total++; if (o !== 1'b1) begin bad++; $display("FAIL lock_keeps_grant got=%b want=1", o); end
      total++; if (!(ag == 16'h3002 && at[0] == 1'b1)) begin bad++; $display("FAIL lock_rmw_write got=%h/%b want=3002/1", ag, at[0]); end
      serve(0, 16'h3333, g, o, p, a, ag, ac, b, at);
      total++; if (!(g && o == 1'b0 && a)) begin bad++; $display("FAIL lock_release got=%b%b%b want=101", g, o, a); end
   endtask

   task automatic test_watchdog();
      bit ok;
      do_reset();
      sel = 1'b0;
      rq0_addr = 16'h6000; rq0_lock = 1'b0; rq0_req = 1'b1;
      wait_grant(ok);
      ce1_tick();
      repeat (254) ce1_tick();
      total++; if (!(ok && fault == 1'b0)) begin bad++; $display("FAIL wd_before_254 got=%b want=0", fault); end
      ce1_tick();
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL wd_at_255 got=%b want=1", fault); end
      repeat (45) ce1_tick();
      dp_ready = 1'b1; dp_din = 16'h5A5A;
      ce1_tick();
      total++; if (rq0_ack !== 1'b1) begin bad++; $display("FAIL wd_ack_late got=%b want=1", rq0_ack); end
      dp_ready = 1'b0; rq0_req = 1'b0;
      @(posedge clk); #1;
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b want=1", fault); end
      total++; if (rq_din !== 16'h5A5A) begin bad++; $display("FAIL wd_rq_din got=%h want=5a5a", rq_din); end
      do_reset();
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL wd_reset_clear got=%b want=0", fault); end
   endtask

   task automatic test_reset_mid();
      bit ok, g, o, p, a, b, any_ack;
      logic [15:0] ag, ac;
      logic [5:0]  at;
      do_reset();
      sel = 1'b0;
      rq0_addr = 16'h7000; rq0_req = 1'b1;
      wait_grant(ok);
      ce1_tick();
      ce1_tick();
      dp_ready = 1'b1; dp_din = 16'h9999;
      n_reset = 1'b0;
      #1;
      total++; if (!(ok && busy == 1'b0 && dp_req == 1'b0)) begin bad++; $display("FAIL midrst_abort got=%b%b%b want=100", ok, busy, dp_req); end
      rq0_req = 1'b0;
      any_ack = 1'b0;
      repeat (3) begin @(posedge clk); #1; any_ack = any_ack | rq0_ack | rq1_ack; end
      n_reset = 1'b1;
      repeat (4) begin @(posedge clk); #1; any_ack = any_ack | rq0_ack | rq1_ack; end
      dp_ready = 1'b0;
      total++; if (any_ack !== 1'b0) begin bad++; $display("FAIL midrst_no_ack got=%b want=0", any_ack); end
      rq0_addr = 16'h7100; rq0_req = 1'b1;
      serve(0, 16'h1357, g, o, p, a, ag, ac, b, at);
      total++; if (!(g && a && ag == 16'h7100)) begin bad++; $display("FAIL midrst_fresh got=%b%b/%h want=11/7100", g, a, ag); end
      total++; if (rq_din !== 16'h1357) begin bad++; $display("FAIL midrst_rq_din got=%h want=1357", rq_din); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      sel = 1'b0;
      rq0_addr = 16'h4000; rq1_addr = 16'h5000; rq1_lock = 1'b0; rq0_lock = 1'b0;
      rq0_req = 1'b1;
      wait_grant(ok);
      repeat (3) ce1_tick();
      rq1_req = 1'b1;
      dp_ready = 1'b1; dp_din = 16'h2468;
      ce1_tick();
      total++; if (!(ok && rq0_ack == 1'b1)) begin bad++; $display("FAIL b2b_ack0 got=%b want=1", rq0_ack); end
      total++; if (dp_addr !== 16'h4000) begin bad++; $display("FAIL b2b_addr_stable got=%h want=4000", dp_addr); end
      total++; if (!(dp_req == 1'b0 && owner == 1'b0)) begin bad++; $display("FAIL b2b_no_same_tick got=%b%b want=00", dp_req, owner); end
      dp_ready = 1'b0; rq0_req = 1'b0;
      @(posedge clk); #1;
      total++; if (dp_req !== 1'b0) begin bad++; $display("FAIL b2b_no_ce2_grant got=%b want=0", dp_req); end
      ce1_tick();
      total++; if (!(dp_req == 1'b1 && owner == 1'b1 && dp_addr == 16'h5000)) begin bad++; $display("FAIL b2b_next_grant got=%b%b/%h want=11/5000", dp_req, owner, dp_addr); end
      repeat (3) ce1_tick();
      dp_ready = 1'b1; dp_din = 16'h8642;
      ce1_tick();
      total++; if (!(rq1_ack == 1'b1 && rq0_ack == 1'b0)) begin bad++; $display("FAIL b2b_ack1 got=%b%b want=10", rq1_ack, rq0_ack); end
      dp_ready = 1'b0; rq1_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      total = 0; bad = 0; sel = 1'b0;
      n_reset = 1'b0; dp_ready = 1'b0; dp_din = 16'h0000;
      rq0_req = 1'b0; rq0_lock = 1'b0; rq0_addr = 16'h0; rq0_dout = 16'h0; rq0_sreg = 2'd0;
      rq0_write = 1'b0; rq0_wide = 1'b0; rq0_io = 1'b0; rq0_zero_seg = 1'b0;
      rq1_req = 1'b0; rq1_lock = 1'b0; rq1_addr = 16'h0; rq1_dout = 16'h0; rq1_sreg = 2'd0;
      rq1_write = 1'b0; rq1_wide = 1'b0; rq1_io = 1'b0; rq1_zero_seg = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_lock();
      test_watchdog();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dp_request_arbiter.md
Name: dp_request_arbiter

Overview:
- Shares the bus control unit's single data-pointer (dp_*) port between two requesters: requester 0 is the execution-unit microcode; requester 1 is the interrupt/stack-push sequencer.
- Latches the winner's request, issues it to the BCU, waits for completion and returns read data with a one-clock acknowledge.
- Provides optional grant locking for read-modify-write sequences, plus a watchdog fault.
- Sits between the execution unit and bus_control_unit.

Parameters:
- RR_MODE, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.
- TIMEOUT, 255, number of ce_1 ticks in WAIT before fault is raised (8-bit counter; 0 disables the watchdog).

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- ce_1  in  1  phase-1 clock enable
- ce_2  in  1  phase-2 clock enable
- rqN_req  in  1  request N (N=0,1); level, held until rqN_ack
- rqN_lock  in  1  keep grant after this access completes
- rqN_addr  in  16  effective address
- rqN_dout  in  16  write data
- rqN_sreg  in  2  segment select (sreg_index_e)
- rqN_write, rqN_wide, rqN_io, rqN_zero_seg  in  1 each  access attributes
- rqN_ack  out  1  one-clk completion pulse
- rq_din  out  16  read data for the last completed access (shared)
- dp_addr, dp_dout  out  16  to BCU
- dp_sreg  out  2  to BCU
- dp_write, dp_wide, dp_io, dp_zero_seg  out  1  to BCU
- dp_req  out  1  to BCU
- dp_ready  in  1  from BCU
- dp_din  in  16  from BCU
- owner  out  1  index of current/last grantee
- busy  out  1  arbiter not in IDLE
- fault  out  1  sticky watchdog fault

Behaviour:
- Reset (async, n_reset low):
  - State IDLE; all outputs 0.
  - rq_din = 16'h0000; owner = 0; last-winner = 1, so requester 0 wins the first tie in RR mode.
  - Watchdog counter = 0; locked = 0.
- State updates, sampling of rqN_* and dp_ready, and data capture happen only on clk edges with ce_1 = 1. dp_req clears on the first clk edge with ce_1 | ce_2.
- IDLE, on ce_1:
  - If locked, only the owner's request is eligible.
  - Otherwise: both requesting → RR picks ~last-winner, fixed mode picks 0; single requester → that one.
  - Latch winner's fields into dp_* registers; set dp_req = 1, owner = winner, busy = 1 → ISSUE.
  - No eligible request: stay IDLE.
- ISSUE:
  - dp_req is high for exactly one enable tick, then clears.
  - On the next ce_1 with dp_req = 0 → WAIT. dp_ready is ignored in ISSUE.
- WAIT, on ce_1:
  - If dp_ready = 1:
    - rq_din <= dp_din (captured for writes too; value is don't-care to the requester).
    - rq{owner}_ack = 1 for exactly one clk.
    - last-winner <= owner; locked <= rq{owner}_lock (sampled now).
    - → IDLE.
  - Otherwise increment the watchdog. When it reaches TIMEOUT, set fault = 1 (sticky until reset) and keep waiting.
  - The watchdog clears on entry to WAIT.
- dp_* address and attribute outputs stay stable from ISSUE through the completing ce_1 of WAIT.
- Requester rules:
  - A requester must not change its fields while req is high; it must drop req the clk after ack.
  - A request still high in the ce_1 where ack is issued is not re-granted.
  - The next grant happens at the earliest on the following ce_1.
- Lock:
  - While locked, the other requester starves.
  - Lock is released at the first completion whose sampled lock = 0, or immediately if the owner's req is low in IDLE.
- Simultaneous events:
  - New requests arriving during ISSUE/WAIT are queued only by their held level; none are lost.
  - ce_1 and ce_2 are never both high.
- n_reset asserted mid-access: all state aborts to IDLE, and no ack is issued.
- Minimum latency for an aligned access: grant ce_1 → ack four ce_1 ticks later, following BCU T_IDLE/T_1/T_2.

Test Plan:
- rq0 aligned wide read at 16'h1234 (DS0), dp_din = 16'hBEEF on completion → dp_req seen for one enable; rq0_ack one clk; rq_din = 16'hBEEF; owner = 0.
- rq0 and rq1 both request, RR_MODE = 1, reset state → grants in order 0, 1, 0, 1 over four back-to-back accesses; with RR_MODE = 0 → 0, 0, 0 while rq0 stays asserted.
- rq1 with lock = 1 (read), rq0 pending → next grant goes to rq1 (write, lock = 0); only then rq0 is granted.
- dp_ready held low for 300 ce_1 ticks, TIMEOUT = 255 → fault rises on tick 255 and stays high after later completion; ack still issued when dp_ready goes high.
- n_reset pulsed low during WAIT → busy = 0, dp_req = 0, no ack; a fresh request afterwards completes normally.
- Request raised in the same ce_1 as another's ack → not granted until the next ce_1; dp_addr is unchanged during the active access.
